// File: rtl/mult_share_arb_if.sv
// Handshake bundle between the two requesters, the arbiter and the shared mult4x4.
// The slave modport is the arbiter's view. The master modport is the requesters' and multiplier's view.
interface mult_share_arb_if;
    logic       req0_valid;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_ready;
    logic       rsp0_valid;
    logic       req1_valid;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_ready;
    logic       rsp1_valid;
    logic [7:0] rsp_product;
    logic       rsp_err;
    logic       mul_start;
    logic [3:0] mul_dataa;
    logic [3:0] mul_datab;
    logic       mul_done;
    logic [7:0] mul_product;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  mul_done, mul_product,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        output rsp_product, rsp_err, mul_start, mul_dataa, mul_datab
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output mul_done, mul_product,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        input  rsp_product, rsp_err, mul_start, mul_dataa, mul_datab
    );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one mult4x4 between two requesters.
// The arbiter sequences start/done and has a timeout guard on the done wait.
module mult_share_arb #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_share_arb_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_rrPtr;
    logic             r_owner;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_product;
    logic             r_err;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_doneOk;
    logic             w_timeout;

    // The pointer side wins when both requesters are valid. Otherwise whichever side is valid wins.
    assign w_grant0  = (r_state == S_IDLE) && bus.req0_valid && (!r_rrPtr || !bus.req1_valid);
    assign w_grant1  = (r_state == S_IDLE) && bus.req1_valid && ( r_rrPtr || !bus.req0_valid);
    // A nonzero count masks a done level left over from the previous operation.
    assign w_doneOk  = bus.mul_done && (r_cnt != '0);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_grant0 || w_grant1) w_nextState = S_ISSUE;
            S_ISSUE: w_nextState = S_WAIT;
            S_WAIT:  if (w_doneOk || w_timeout) w_nextState = S_RESP;
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready  = w_grant0;
        bus.req1_ready  = w_grant1;
        bus.mul_start   = (r_state == S_ISSUE);
        bus.rsp0_valid  = (r_state == S_RESP) && !r_owner;
        bus.rsp1_valid  = (r_state == S_RESP) &&  r_owner;
        bus.rsp_product = r_product;
        bus.rsp_err     = r_err;
        bus.mul_dataa   = r_a;
        bus.mul_datab   = r_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrPtr   <= 1'b0;
            r_owner   <= 1'b0;
            r_a       <= 4'h0;
            r_b       <= 4'h0;
            r_cnt     <= '0;
            r_product <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0) begin
                        r_a     <= bus.req0_a;
                        r_b     <= bus.req0_b;
                        r_owner <= 1'b0;
                    end else if (w_grant1) begin
                        r_a     <= bus.req1_a;
                        r_b     <= bus.req1_b;
                        r_owner <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // When done and timeout occur in the same cycle, done has priority.
                    if (w_doneOk) begin
                        r_product <= bus.mul_product;
                        r_err     <= 1'b0;
                    end else if (w_timeout) begin
                        r_product <= 8'h00;
                        r_err     <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_rrPtr <= ~r_owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb. It uses a mult4x4 stub with selectable latency, stuck-low and stuck-high modes.
// A priority model decides which requester each transaction should go to.
module tb_mult_share_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult_share_arb_if bus();

    mult_share_arb #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The multiplier stub holds done as a level until the next start, like the real done_flag.
    int         mulMode   = 0;
    int         mulLat    = 2;
    int         mulCnt    = 0;
    bit         mulBusy   = 1'b0;
    logic [3:0] la        = 4'h0;
    logic [3:0] lb        = 4'h0;
    logic [7:0] stuckProd = 8'hA5;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mul_done    <= 1'b0;
            bus.mul_product <= 8'h00;
            mulBusy         <= 1'b0;
        end else if (mulMode == 1) begin
            bus.mul_done <= 1'b0;
        end else if (mulMode == 2) begin
            bus.mul_done    <= 1'b1;
            bus.mul_product <= stuckProd;
        end else if (bus.mul_start) begin
            mulBusy      <= 1'b1;
            mulCnt       <= mulLat;
            la           <= bus.mul_dataa;
            lb           <= bus.mul_datab;
            bus.mul_done <= 1'b0;
        end else if (mulBusy) begin
            if (mulCnt == 1) begin
                bus.mul_done    <= 1'b1;
                bus.mul_product <= {4'h0, la} * {4'h0, lb};
                mulBusy         <= 1'b0;
            end else begin
                mulCnt <= mulCnt - 1;
            end
        end
    end

    int         startCount = 0;
    logic [3:0] startA     = 4'h0;
    logic [3:0] startB     = 4'h0;

    always @(negedge clk) begin
        if (bus.mul_start === 1'b1) begin
            startCount++;
            startA = bus.mul_dataa;
            startB = bus.mul_datab;
        end
    end

    task automatic setReq(input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                          input bit v1, input logic [3:0] a1, input logic [3:0] b1);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
    endtask

    task automatic doReset();
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        mulMode = 0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic acceptOne(output int side, output int waited, output bit both);
        side   = -1;
        waited = 0;
        both   = 1'b0;
        while (side < 0 && waited < 40) begin
            @(negedge clk);
            waited++;
            if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both = 1'b1;
            if (bus.req0_ready === 1'b1) side = 0;
            else if (bus.req1_ready === 1'b1) side = 1;
        end
        if (side >= 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitResponse(input logic [3:0] ea, input logic [3:0] eb, output int owner,
                                output logic [7:0] prod, output logic err, output int cycles,
                                output int badBusy);
        owner   = -1;
        cycles  = 0;
        badBusy = 0;
        prod    = 8'h00;
        err     = 1'b0;
        while (owner < 0 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) badBusy++;
            if (bus.rsp0_valid === 1'b1 && bus.rsp1_valid === 1'b1) badBusy++;
            if (bus.rsp0_valid === 1'b1) owner = 0;
            else if (bus.rsp1_valid === 1'b1) owner = 1;
            if (owner < 0 && (bus.mul_dataa !== ea || bus.mul_datab !== eb)) badBusy++;
            if (owner >= 0) begin
                prod = bus.rsp_product;
                err  = bus.rsp_err;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int expCycles(input int lat);
        int k;
        k = (lat + 1 > 2) ? lat + 1 : 2;
        if (k > 15) k = 15;
        return 2 + k;
    endfunction

    task automatic test_reset();
        logic [21:0] obs;
        int side, waited, owner, cycles, badBusy, rspSeen;
        bit both;
        logic [7:0] prod;
        logic err;
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        obs = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err,
               bus.mul_start, bus.rsp_product, bus.mul_dataa, bus.mul_datab};
        checks++;
        if (obs !== 22'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h expected 0", obs);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        mulLat = 2;
        setReq(1, 4'h2, 4'h3, 0, 4'h0, 4'h0);
        acceptOne(side, waited, both);
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        waitResponse(4'h2, 4'h3, owner, prod, err, cycles, badBusy);

        mulMode = 1;
        setReq(0, 4'h0, 4'h0, 1, 4'h4, 4'h4);
        acceptOne(side, waited, both);
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err,
               bus.mul_start, bus.rsp_product, bus.mul_dataa, bus.mul_datab};
        checks++;
        if (obs !== 22'h0) begin
            errors++;
            $display("[TB] FAIL reset_midwait got %h expected 0", obs);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mulMode = 0;

        rspSeen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) rspSeen++;
        end
        checks++;
        if (rspSeen !== 0) begin
            errors++;
            $display("[TB] FAIL reset_silent rsp cycles %0d expected 0", rspSeen);
        end

        @(posedge clk);
        #1;
        setReq(1, 4'h5, 4'h6, 1, 4'h7, 4'h8);
        acceptOne(side, waited, both);
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        checks++;
        if (side !== 0 || both) begin
            errors++;
            $display("[TB] FAIL reset_rrptr got side %0d both %0d expected 0 0", side, both);
        end
        waitResponse(4'h5, 4'h6, owner, prod, err, cycles, badBusy);
        checks++;
        if (owner !== 0 || prod !== 8'd30 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_firstop got owner %0d prod %h err %b expected 0 1e 0",
                     owner, prod, err);
        end
    endtask

    task automatic test_single();
        int side, waited, owner, cycles, badBusy, s0;
        bit both;
        logic [7:0] prod;
        logic err;
        doReset();
        mulLat = 3;
        s0 = startCount;
        setReq(1, 4'hF, 4'hF, 0, 4'h0, 4'h0);
        acceptOne(side, waited, both);
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        checks++;
        if (side !== 0 || waited !== 1) begin
            errors++;
            $display("[TB] FAIL single_accept got side %0d wait %0d expected 0 1", side, waited);
        end
        waitResponse(4'hF, 4'hF, owner, prod, err, cycles, badBusy);
        checks++;
        if (owner !== 0 || prod !== 8'hE1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_rsp got owner %0d prod %h err %b expected 0 e1 0",
                     owner, prod, err);
        end
        checks++;
        if (cycles !== expCycles(3) || badBusy !== 0) begin
            errors++;
            $display("[TB] FAIL single_timing got cycles %0d bad %0d expected %0d 0",
                     cycles, badBusy, expCycles(3));
        end
        checks++;
        if (startCount - s0 !== 1 || startA !== 4'hF || startB !== 4'hF) begin
            errors++;
            $display("[TB] FAIL single_start got pulses %0d a %h b %h expected 1 f f",
                     startCount - s0, startA, startB);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pulse got rsp0_valid %b after pulse expected 0", bus.rsp0_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_both();
        int side, waited, owner, cycles, badBusy;
        bit both;
        logic [7:0] prod;
        logic err;
        int expSide[3] = '{0, 1, 0};
        logic [7:0] expProd[3] = '{8'h0F, 8'h3F, 8'h0F};
        doReset();
        mulLat = 2;
        setReq(1, 4'h3, 4'h5, 1, 4'h7, 4'h9);
        for (int i = 0; i < 3; i++) begin
            acceptOne(side, waited, both);
            checks++;
            if (side !== expSide[i] || both) begin
                errors++;
                $display("[TB] FAIL both_grant%0d got side %0d both %0d expected %0d 0",
                         i, side, both, expSide[i]);
            end
            if (expSide[i] == 0) waitResponse(4'h3, 4'h5, owner, prod, err, cycles, badBusy);
            else waitResponse(4'h7, 4'h9, owner, prod, err, cycles, badBusy);
            checks++;
            if (owner !== expSide[i] || prod !== expProd[i] || err !== 1'b0 || badBusy !== 0) begin
                errors++;
                $display("[TB] FAIL both_rsp%0d got owner %0d prod %h err %b bad %0d expected %0d %h 0 0",
                         i, owner, prod, err, badBusy, expSide[i], expProd[i]);
            end
        end
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
    endtask

    task automatic test_no_starve();
        int side, waited, owner, cycles, badBusy;
        bit both;
        logic [7:0] prod;
        logic err;
        logic [3:0] av[2] = '{4'h7, 4'h2};
        logic [3:0] bv[2] = '{4'h9, 4'h6};
        logic [7:0] ep[2] = '{8'h3F, 8'h0C};
        for (int i = 0; i < 2; i++) begin
            setReq(0, 4'h0, 4'h0, 1, av[i], bv[i]);
            acceptOne(side, waited, both);
            setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
            waitResponse(av[i], bv[i], owner, prod, err, cycles, badBusy);
            checks++;
            if (side !== 1 || owner !== 1 || prod !== ep[i] || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL starve%0d got side %0d owner %0d prod %h err %b expected 1 1 %h 0",
                         i, side, owner, prod, err, ep[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int side, waited, owner, cycles, badBusy;
        bit both;
        logic [7:0] prod;
        logic err;
        doReset();
        mulMode = 1;
        setReq(1, 4'h9, 4'h9, 0, 4'h0, 4'h0);
        acceptOne(side, waited, both);
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        waitResponse(4'h9, 4'h9, owner, prod, err, cycles, badBusy);
        checks++;
        if (owner !== 0 || prod !== 8'h00 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_rsp got owner %0d prod %h err %b expected 0 00 1",
                     owner, prod, err);
        end
        checks++;
        if (cycles !== 17) begin
            errors++;
            $display("[TB] FAIL timeout_len got %0d cycles expected 17", cycles);
        end
        mulMode = 0;
        mulLat  = 1;
        setReq(0, 4'h0, 4'h0, 1, 4'h1, 4'h1);
        acceptOne(side, waited, both);
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        checks++;
        if (side !== 1 || waited !== 1) begin
            errors++;
            $display("[TB] FAIL timeout_idle got side %0d wait %0d expected 1 1", side, waited);
        end
        waitResponse(4'h1, 4'h1, owner, prod, err, cycles, badBusy);
    endtask

    task automatic test_stale_done();
        int side, waited, owner, cycles, badBusy;
        bit both;
        logic [7:0] prod;
        logic err;
        doReset();
        mulMode = 2;
        @(posedge clk);
        #1;
        setReq(1, 4'h6, 4'h7, 0, 4'h0, 4'h0);
        acceptOne(side, waited, both);
        setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
        waitResponse(4'h6, 4'h7, owner, prod, err, cycles, badBusy);
        checks++;
        if (cycles !== 4 || owner !== 0 || prod !== 8'hA5 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stale_done got cycles %0d owner %0d prod %h err %b expected 4 0 a5 0",
                     cycles, owner, prod, err);
        end
        mulMode = 0;
    endtask

    task automatic test_random();
        int side, waited, owner, cycles, badBusy, expSide, prio, lat;
        bit both, v0, v1;
        logic [7:0] prod, ep;
        logic err;
        logic [3:0] a0, b0, a1, b1, ea, eb;
        doReset();
        // The most recently served requester loses priority when both requesters are valid.
        prio = 0;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            a0 = 4'($urandom); b0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom);
            lat = int'($urandom_range(1, 6));
            mulLat = lat;
            expSide = (v0 && v1) ? prio : (v0 ? 0 : 1);
            ea = (expSide == 0) ? a0 : a1;
            eb = (expSide == 0) ? b0 : b1;
            ep = {4'h0, ea} * {4'h0, eb};
            setReq(v0, a0, b0, v1, a1, b1);
            acceptOne(side, waited, both);
            setReq(0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
            checks++;
            if (side !== expSide || both || waited !== 1) begin
                errors++;
                $display("[TB] FAIL rand_grant%0d got side %0d both %0d wait %0d expected %0d 0 1",
                         i, side, both, waited, expSide);
            end
            if (side < 0) break;
            waitResponse(ea, eb, owner, prod, err, cycles, badBusy);
            checks++;
            if (owner !== expSide || prod !== ep || err !== 1'b0 || cycles !== expCycles(lat)
                || badBusy !== 0) begin
                errors++;
                $display("[TB] FAIL rand_rsp%0d got owner %0d prod %h err %b cyc %0d bad %0d expected %0d %h 0 %0d 0",
                         i, owner, prod, err, cycles, badBusy, expSide, ep, expCycles(lat));
            end
            prio = 1 - expSide;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_no_starve();
        test_timeout();
        test_stale_done();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not complete, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
